// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit holding register between N requesters,
// with locked bursts of up to MAX_BURST writes and a force-clear override.
module shared_reg_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [N*W-1:0]   wdata,
    input  logic             force_clr,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     q,
    output logic             q_valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;

    logic [IW-1:0]   nxtOwner;
    logic [IW-1:0]   winIdle;
    logic [IW-1:0]   winRel;
    logic [W-1:0]    ownerData;
    logic            rel;

    // First set bit of r scanning upward (with wrap) from index p.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && r[idx]) begin
                w     = idx[IW-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign nxtOwner  = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign winIdle   = pick(req, ptr_q);
    assign winRel    = pick(req, nxtOwner);
    assign ownerData = wdata[int'(owner_q)*W +: W];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        rel     = 1'b0;

        if (force_clr) begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gnt_d = '0;
                    if (|req) begin
                        gnt_d[winIdle] = 1'b1;
                        owner_d        = winIdle;
                        cnt_d          = '0;
                        state_d        = OWN;
                    end
                end
                OWN: begin
                    rel = 1'b1;
                    if (req[owner_q]) begin
                        data_d  = ownerData;
                        valid_d = 1'b1;
                        if (lock[owner_q] && ((int'(cnt_q) + 1) < MAX_BURST)) begin
                            cnt_d = cnt_q + 1'b1;
                            rel   = 1'b0;
                        end
                    end
                    // Releasing hands over in the same edge; the old owner is considered last.
                    if (rel) begin
                        ptr_d = nxtOwner;
                        gnt_d = '0;
                        cnt_d = '0;
                        if (|req) begin
                            gnt_d[winRel] = 1'b1;
                            owner_d       = winRel;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed walkthrough plus randomized traffic,
// scored against an integer-level arbitration model through an expectation queue.
module tb_shared_reg_arbiter;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] q;
        logic         v;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*W-1:0]  wdata;
    logic            force_clr;
    logic [N-1:0]    gnt;
    logic [W-1:0]    q;
    logic            q_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model state: owner -1 means nobody holds the register.
    int          mOwner = -1;
    int          mPtr   = 0;
    int          mCnt   = 0;
    logic [W-1:0] mQ    = '0;
    logic        mValid = 1'b0;
    int          mO;
    logic        mRel;
    exp_t        mExp;
    exp_t        popped;

    shared_reg_arbiter #(.N(N), .W(W), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .wdata     (wdata),
        .force_clr (force_clr),
        .gnt       (gnt),
        .q         (q),
        .q_valid   (q_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int mPick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Model advances on every rising edge using the inputs that edge sees.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mOwner = -1; mPtr = 0; mCnt = 0; mQ = '0; mValid = 1'b0;
            end else if (force_clr) begin
                mOwner = -1; mCnt = 0; mQ = '0; mValid = 1'b0;
            end else if (mOwner < 0) begin
                if (req != '0) begin
                    mOwner = mPick(req, mPtr);
                    mCnt   = 0;
                end
            end else begin
                mO   = mOwner;
                mRel = 1'b1;
                if (req[mO]) begin
                    mQ     = wdata[mO*W +: W];
                    mValid = 1'b1;
                    if (lock[mO] && (mCnt + 1 < MAX_BURST)) begin
                        mCnt = mCnt + 1;
                        mRel = 1'b0;
                    end
                end
                if (mRel) begin
                    mPtr   = (mO + 1) % N;
                    mCnt   = 0;
                    mOwner = (req != '0) ? mPick(req, mPtr) : -1;
                end
            end
            mExp.gnt = (mOwner < 0) ? '0 : N'(1) << mOwner;
            mExp.q   = mQ;
            mExp.v   = mValid;
            sb.push_back(mExp);
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                popped = sb.pop_front();
                checks++;
                if (gnt !== popped.gnt || q !== popped.q || q_valid !== popped.v) begin
                    errors++;
                    $display("[TB] FAIL scoreboard t=%0t got gnt=%b q=%h v=%b expected gnt=%b q=%h v=%b",
                             $time, gnt, q, q_valid, popped.gnt, popped.q, popped.v);
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic fc, input logic [N-1:0] rq,
                                 input logic [N-1:0] lk, input logic [N*W-1:0] wd);
        reset     = r;
        force_clr = fc;
        req       = rq;
        lock      = lk;
        wdata     = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg,
                               input logic [W-1:0] eq, input logic ev);
        checks++;
        if (gnt !== eg || q !== eq || q_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s got gnt=%b q=%h v=%b expected gnt=%b q=%h v=%b",
                     name, gnt, q, q_valid, eg, eq, ev);
        end
    endtask

    localparam logic [N*W-1:0] D0 = 32'h44332211;
    localparam logic [N*W-1:0] D1 = 32'h44A52211;

    initial begin
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("reset_c1", 4'b0000, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("reset_c2", 4'b0000, 8'h00, 1'b0);

        // Round robin across all four requesters.
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("rr_first", 4'b0001, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("rr_1", 4'b0010, 8'h11, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("rr_2", 4'b0100, 8'h22, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("rr_3", 4'b1000, 8'h33, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, D0);
        checkOutput("rr_wrap", 4'b0001, 8'h44, 1'b1);

        // Locked burst by requester 1 lasts MAX_BURST writes.
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
        checkOutput("burst_start", 4'b0010, 8'h11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
            checkOutput("burst_hold", 4'b0010, 8'h22, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
        checkOutput("burst_end", 4'b0001, 8'h22, 1'b1);

        // Force-clear mid-burst, pointer retained afterwards.
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
        checkOutput("fc_pre0", 4'b0010, 8'h11, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
        checkOutput("fc_pre1", 4'b0010, 8'h22, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'b0011, 4'b0010, D0);
        checkOutput("fc_pulse", 4'b0000, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
        checkOutput("fc_regrant", 4'b0010, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0010, D0);
        checkOutput("fc_write", 4'b0010, 8'h22, 1'b1);

        // Owner abandons: no write, handover at the same edge.
        applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0000, D0);
        checkOutput("abandon", 4'b0100, 8'h22, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0000, D1);
        checkOutput("single_w", 4'b0100, 8'hA5, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0000, D1);
        checkOutput("single_regrant", 4'b0100, 8'hA5, 1'b1);

        // Randomized traffic with sticky requests and occasional clears/resets.
        begin
            logic [N-1:0] rq;
            rq = 4'b0000;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) rq = N'($urandom);
                applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 24) == 0,
                              rq, N'($urandom), (N*W)'($urandom));
            end
        end

        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, D0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one W-bit holding register between N requesters. Each requester may hold the register for a locked burst of up to MAX_BURST writes. A force-clear input pins the register to zero and drops all grants. After force-clear is released, the register keeps 0 until the next granted write. The block sits in front of any shared state register that several pipeline units update.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data width of the shared register
MAX_BURST, 4, maximum writes per locked tenure (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  N  per-requester write request, level; held until served or abandoned
lock  input  N  per-requester burst request; sampled with req
wdata  input  N*W  packed write data; slice i = wdata[i*W +: W]
force_clr  input  1  level; while high: q forced 0, grants dropped
gnt  output  N  registered one-hot grant, or all zero
q  output  W  shared register contents
q_valid  output  1  high once q holds requester-written data

Behaviour:
- Internal state: fsm {IDLE, OWN}; owner (log2 N bits); rr pointer ptr (log2 N bits); write counter cnt (0..MAX_BURST-1).
- Priority at each edge: reset > force_clr > normal operation.
- Reset: fsm=IDLE, gnt=0, q=0, q_valid=0, ptr=0, owner=0, cnt=0.
  - Reset mid-burst aborts the tenure with no write.
- force_clr=1 at an edge: same as reset, except ptr is retained.
  - While force_clr is high, no writes and no grants occur.
  - On the first edge after force_clr falls, normal arbitration resumes. q stays 0 until the next write.
- Round-robin pick from pointer p: the first index in order p, p+1, ..., p+N-1 (mod N) whose req bit is 1.
- IDLE:
  - If |req at the edge: gnt <= onehot(pick(ptr)), owner <= winner, cnt <= 0, fsm <= OWN.
  - Otherwise remain in IDLE with gnt=0.
- OWN, with o = owner and gnt[o]=1, at each edge:
  - req[o]=0: no write; release.
  - req[o]=1: q <= wdata slice o; q_valid <= 1.
    - If lock[o]=1 and cnt+1 < MAX_BURST: cnt <= cnt+1, stay with owner o.
    - Otherwise: release.
- Release at that same edge:
  - ptr <= (o+1) mod N.
  - If any req is set: winner = pick((o+1) mod N); gnt <= onehot(winner), owner <= winner, cnt <= 0, remain OWN. There is no idle bubble; o itself is considered last.
  - Otherwise gnt <= 0, fsm <= IDLE.
- Latency:
  - req seen at edge t gives gnt high after t.
  - The first write into q occurs at edge t+1.
  - q is visible after t+1.
- q changes only on a write, reset, or force_clr. gnt is never multi-hot.
- Simultaneous reset and force_clr: reset wins, and ptr is cleared to 0.
- MAX_BURST=1: lock has no effect; every tenure is one write.
- req for non-owners is ignored until a release. Requesters hold req; a dropped req loses its place only if it is low at the pick edge.

Test Plan:
1. Reset held 2 cycles, with req=4'b1111 and force_clr=0 -> gnt=0, q=8'h00, q_valid=0 throughout; first grant after release is gnt=4'b0001.
2. Single requester: req=4'b0100, lock=0, slice2=8'hA5 -> gnt=4'b0100 after edge 1; q=8'hA5 and q_valid=1 after edge 2; gnt stays 4'b0100 (re-grant) while req holds.
3. Round robin: req=4'b1111, lock=0, slices 11/22/33/44 -> gnt sequence 0001,0010,0100,1000,0001; q follows 11,22,33,44 one edge behind.
4. Burst: req=4'b0011, lock=4'b0010, MAX_BURST=4 -> gnt 0001 for 1 cycle, then 0010 for 4 cycles, then 0001; q holds slice0, then 4 writes of slice1, then slice0.
5. force_clr mid-burst: single-cycle pulse during the 0010 burst -> next edge gnt=0, q=0, q_valid=0. After the pulse, gnt goes to 0010 one edge later (ptr retained), and q stays 0 until the following edge.
6. Owner abandons: req goes 4'b0110 -> 4'b0100 while gnt=0010 -> no write that edge, q unchanged, gnt=0100 at that same edge.
